// File: rtl/key_event_if.sv
// Key event bundle between the key debouncer side (master) and the event decoder (slave).
// key_i is active-low. All event outputs are single-cycle pulses; held_o is a level.
interface key_event_if #(
    parameter int NKEY = 2
);
    logic [NKEY-1:0] key_i;
    logic [NKEY-1:0] press_o;
    logic [NKEY-1:0] release_o;
    logic [NKEY-1:0] long_press_o;
    logic [NKEY-1:0] repeat_o;
    logic [NKEY-1:0] held_o;

    modport master (
        output key_i,
        input  press_o, release_o, long_press_o, repeat_o, held_o
    );

    modport slave (
        input  key_i,
        output press_o, release_o, long_press_o, repeat_o, held_o
    );
endinterface

// File: rtl/key_event_decoder.sv
// Turns debounced active-low key levels into press/release/long-press pulses per key.
// Define KEY_AUTOREPEAT_EN to emit repeat pulses every REPEAT_MS ticks while in HOLD.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | key released, waiting for synchronized level to go low
//   ST_DOWN | key pressed, counting ticks towards LONG_MS
//   ST_HOLD | long press reached; auto-repeat counting (if enabled)
module key_event_decoder #(
    parameter int NKEY      = 2,
    parameter int TICK_DIV  = 99999,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    key_event_if.slave kif
);
    localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [NKEY-1:0]  s1_q, s2_q;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick;
    state_t           st_q  [NKEY];
    logic [CNT_W-1:0] cnt_q [NKEY];
    logic [NKEY-1:0]  press_q, release_q, long_q, repeat_q, held_q;

    // Terminal count of the per-key counter depends on which hold phase the key is in.
    function automatic logic [CNT_W-1:0] term_cnt(input state_t s);
        return (s == ST_HOLD) ? CNT_W'(REPEAT_MS - 1) : CNT_W'(LONG_MS - 1);
    endfunction

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '1;
            s2_q       <= '1;
            tick_cnt_q <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            repeat_q   <= '0;
            held_q     <= '0;
            for (int i = 0; i < NKEY; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q       <= kif.key_i;
            s2_q       <= s1_q;
            tick_cnt_q <= tick_cnt_d;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            repeat_q   <= '0;
            for (int i = 0; i < NKEY; i++) begin
                case (st_q[i])
                    ST_IDLE: begin
                        if (!s2_q[i]) begin
                            press_q[i] <= 1'b1;
                            held_q[i]  <= 1'b1;
                            cnt_q[i]   <= '0;
                            st_q[i]    <= ST_DOWN;
                        end
                    end
                    ST_DOWN: begin
                        // Release is tested first so it beats a coincident terminal tick.
                        if (s2_q[i]) begin
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                            st_q[i]      <= ST_IDLE;
                        end else if (tick) begin
                            if (cnt_q[i] == term_cnt(ST_DOWN)) begin
                                long_q[i] <= 1'b1;
                                cnt_q[i]  <= '0;
                                st_q[i]   <= ST_HOLD;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (s2_q[i]) begin
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                            st_q[i]      <= ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                        end else if (tick) begin
                            if (cnt_q[i] == term_cnt(ST_HOLD)) begin
                                repeat_q[i] <= 1'b1;
                                cnt_q[i]    <= '0;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
`endif
                        end
                    end
                    default: begin
                        held_q[i] <= 1'b0;
                        cnt_q[i]  <= '0;
                        st_q[i]   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign kif.press_o      = press_q;
    assign kif.release_o    = release_q;
    assign kif.long_press_o = long_q;
    assign kif.repeat_o     = repeat_q;
    assign kif.held_o       = held_q;
endmodule
